// File: rtl/rsp_s2_prep_integ_if.sv
// Lane-parallel sample stream: BURST_LEN-style packed lanes, beat qualifier and frame-end marker.
`timescale 1ns/1ps
interface rsp_s2_prep_integ_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 16
);
    logic [LANES-1:0][LANE_W-1:0] data;
    logic                         valid;
    logic                         last;

    modport master (output data, valid, last);
    modport slave  (input  data, valid, last);
endinterface

// File: rtl/rsp_s2_prep_integ.sv
// Stage-2 integrator: rebuilds samples from lag-1 or lag-2 differences, two-cycle pipeline,
// saturating to the lane width, with frame-length checking.
`timescale 1ns/1ps
module rsp_s2_prep_integ #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int BURST_LEN    = 8,
    parameter int DATA_NUM     = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_switch,
    rsp_s2_prep_integ_if.slave   d_bus,
    rsp_s2_prep_integ_if.master  x_bus,
    output logic                 o_sat,
    output logic                 o_frame_err
);
    localparam int LANE_W = SAMPLE_WIDTH / 2;
    localparam int ACC_W  = LANE_W + 4;
    localparam int CNT_W  = $clog2(DATA_NUM) + 1;
    localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(DATA_NUM - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2 ** (LANE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-(2 ** (LANE_W - 1)));

    function automatic logic clips(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [LANE_W-1:0] sat_lane(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return LANE_W'(SAT_MAX);
        if (v < SAT_MIN) return LANE_W'(SAT_MIN);
        return $signed(v[LANE_W-1:0]);
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic                    mode_q;
    logic                    first_beat, mode_now, at_wrap, frame_err_now;
    logic signed [ACC_W-1:0] psum [BURST_LEN];

    logic                    vld_p1, last_p1, err_p1, first_p1, mode_p1;
    logic signed [ACC_W-1:0] psum_p1 [BURST_LEN];

    logic signed [LANE_W-1:0] c_even, c_odd;
    logic signed [LANE_W-1:0] carry_k [BURST_LEN];
    logic signed [ACC_W-1:0]  sum_k [BURST_LEN];
    logic signed [LANE_W-1:0] xs [BURST_LEN];
    logic                     any_clip;

    logic                            vld_p2, last_p2;
    logic [BURST_LEN-1:0][LANE_W-1:0] data_p2;

    // Stage 0: framing decode and intra-beat prefix sums (mode latched at beat 0).
    always_comb begin
        first_beat    = (cnt == '0);
        mode_now      = first_beat ? i_switch : mode_q;
        at_wrap       = (cnt == LAST_BEAT);
        frame_err_now = d_bus.last ^ at_wrap;
        for (int k = 0; k < BURST_LEN; k++)
            psum[k] = ACC_W'($signed(d_bus.data[k]));
        if (mode_now) begin
            for (int k = 1; k < BURST_LEN; k++)
                psum[k] = psum[k] + psum[k-1];
        end else begin
            for (int k = 2; k < BURST_LEN; k++)
                psum[k] = psum[k] + psum[k-2];
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            mode_q   <= 1'b0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            err_p1   <= 1'b0;
            first_p1 <= 1'b0;
            mode_p1  <= 1'b0;
            psum_p1  <= '{default: '0};
        end else begin
            vld_p1 <= d_bus.valid;
            if (d_bus.valid) begin
                psum_p1  <= psum;
                last_p1  <= d_bus.last;
                err_p1   <= frame_err_now;
                first_p1 <= first_beat;
                mode_p1  <= mode_now;
                if (first_beat)
                    mode_q <= i_switch;
                cnt <= (d_bus.last || at_wrap) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Stage 2: add lane carry (lag-1 shares the odd carry, which is always the last lane).
    always_comb begin
        any_clip = 1'b0;
        for (int k = 0; k < BURST_LEN; k++) begin
            if (first_p1)
                carry_k[k] = '0;
            else if (mode_p1 || (k % 2 == 1))
                carry_k[k] = c_odd;
            else
                carry_k[k] = c_even;
            sum_k[k] = psum_p1[k] + ACC_W'(carry_k[k]);
            xs[k]    = sat_lane(sum_k[k]);
            any_clip = any_clip | clips(sum_k[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2      <= 1'b0;
            last_p2     <= 1'b0;
            o_frame_err <= 1'b0;
            o_sat       <= 1'b0;
            data_p2     <= '0;
            c_even      <= '0;
            c_odd       <= '0;
        end else begin
            vld_p2      <= vld_p1;
            last_p2     <= vld_p1 & last_p1;
            o_frame_err <= vld_p1 & err_p1;
            if (vld_p1) begin
                for (int k = 0; k < BURST_LEN; k++)
                    data_p2[k] <= xs[k];
                c_odd  <= xs[BURST_LEN-1];
                c_even <= xs[BURST_LEN-2];
                o_sat  <= any_clip | (o_sat & ~first_p1);
            end
        end
    end

    assign x_bus.data  = data_p2;
    assign x_bus.valid = vld_p2;
    assign x_bus.last  = last_p2;
endmodule

// File: tb/tb_rsp_s2_prep_integ.sv
// Directed bench for rsp_s2_prep_integ: vector table, long round-trip frames, gap and reset sequences.
`timescale 1ns/1ps
module tb_rsp_s2_prep_integ;
    typedef logic [7:0][15:0] beat_t;
    typedef struct {
        bit sw; bit vld; bit last; beat_t d;
        beat_t x; bit xl; bit err; bit sat;
    } vec_t;
    typedef struct {
        int id; bit vld; beat_t x; bit xl; bit err; bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw = 1'b0;
    logic o_sat, o_frame_err;

    rsp_s2_prep_integ_if #(.LANES(8), .LANE_W(16)) d_bus ();
    rsp_s2_prep_integ_if #(.LANES(8), .LANE_W(16)) x_bus ();

    rsp_s2_prep_integ #(.SAMPLE_WIDTH(32), .BURST_LEN(8), .DATA_NUM(1024)) dut (
        .clk(clk), .rst_n(rst_n), .i_switch(sw),
        .d_bus(d_bus), .x_bus(x_bus),
        .o_sat(o_sat), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    tick_id  = 0;
    exp_t  sbq[$];
    beat_t hold_x   = '0;
    bit    hold_sat = 1'b0;
    vec_t  tbl[12];

    function automatic beat_t lanes(input int a0, a1, a2, a3, a4, a5, a6, a7);
        beat_t b;
        b[0] = 16'(a0); b[1] = 16'(a1); b[2] = 16'(a2); b[3] = 16'(a3);
        b[4] = 16'(a4); b[5] = 16'(a5); b[6] = 16'(a6); b[7] = 16'(a7);
        return b;
    endfunction

    function automatic beat_t fill(input int v);
        return lanes(v, v, v, v, v, v, v, v);
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic check_out(input exp_t e);
        n_checks++;
        if (x_bus.valid !== e.vld || x_bus.data !== e.x || x_bus.last !== e.xl ||
            o_frame_err !== e.err || o_sat !== e.sat) begin
            n_fail++;
            $display("FAIL out[%0d]: got vld=%0b last=%0b err=%0b sat=%0b x=%h, want vld=%0b last=%0b err=%0b sat=%0b x=%h",
                     e.id, x_bus.valid, x_bus.last, o_frame_err, o_sat, x_bus.data,
                     e.vld, e.xl, e.err, e.sat, e.x);
        end
    endtask

    // One clock: check the output due now, drive the next input, queue its expectation.
    task automatic tick(input bit s, input bit v, input bit l, input beat_t d, input exp_t e);
        @(negedge clk);
        if (sbq.size() == 2) check_out(sbq.pop_front());
        sw = s;
        d_bus.valid = v;
        d_bus.last  = l;
        d_bus.data  = d;
        e.id = tick_id++;
        e.vld = v;
        if (!v) begin
            e.x = hold_x; e.sat = hold_sat; e.xl = 1'b0; e.err = 1'b0;
        end
        hold_x = e.x;
        hold_sat = e.sat;
        sbq.push_back(e);
    endtask

    task automatic idle();
        exp_t e;
        e = '{id: 0, vld: 1'b0, x: '0, xl: 1'b0, err: 1'b0, sat: 1'b0};
        tick(1'b0, 1'b0, 1'b0, '0, e);
    endtask

    // Frame built from known samples; differences computed here, recovery expected exactly.
    task automatic run_frame(input bit s, input int nbeats, input bit with_last,
                             input int gap_at, input bit rnd, input int base);
        int p1, p2, xv, dv;
        beat_t d, x;
        bit l;
        exp_t e;
        p1 = 0; p2 = 0;
        for (int b = 0; b < nbeats; b++) begin
            if (b == gap_at) begin
                idle(); idle(); idle();
            end
            for (int k = 0; k < 8; k++) begin
                if (rnd) xv = int'($urandom_range(8000)) - 4000;
                else     xv = ((b * 37 + k * 11 + base) % 200) - 100;
                dv = xv - (s ? p1 : p2);
                p2 = p1;
                p1 = xv;
                d[k] = 16'(dv);
                x[k] = 16'(xv);
            end
            l = with_last && (b == nbeats - 1);
            e = '{id: 0, vld: 1'b1, x: x, xl: l, err: (l && b != 1023) || (b == 1023 && !l), sat: 1'b0};
            tick(s, 1'b1, l, d, e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got no end, want end");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        d_bus.valid = 1'b0;
        d_bus.last  = 1'b0;
        d_bus.data  = '0;

        tbl[0]  = '{sw: 1, vld: 1, last: 0, d: fill(1),                       x: lanes(1,2,3,4,5,6,7,8),      xl: 0, err: 0, sat: 0};
        tbl[1]  = '{sw: 1, vld: 1, last: 0, d: lanes(2,0,0,0,0,0,0,0),        x: fill(10),                    xl: 0, err: 0, sat: 0};
        tbl[2]  = '{sw: 1, vld: 1, last: 1, d: fill(0),                       x: fill(10),                    xl: 1, err: 1, sat: 0};
        tbl[3]  = '{sw: 0, vld: 1, last: 0, d: lanes(5,7,1,1,1,1,1,1),        x: lanes(5,7,6,8,7,9,8,10),     xl: 0, err: 0, sat: 0};
        tbl[4]  = '{sw: 0, vld: 0, last: 0, d: fill(3),                       x: fill(0),                     xl: 0, err: 0, sat: 0};
        tbl[5]  = '{sw: 1, vld: 1, last: 0, d: fill(0),                       x: lanes(8,10,8,10,8,10,8,10),  xl: 0, err: 0, sat: 0};
        tbl[6]  = '{sw: 0, vld: 1, last: 1, d: fill(0),                       x: lanes(8,10,8,10,8,10,8,10),  xl: 1, err: 1, sat: 0};
        tbl[7]  = '{sw: 1, vld: 1, last: 1, d: lanes(32767,1,0,0,0,0,0,0),    x: fill(32767),                 xl: 1, err: 1, sat: 1};
        tbl[8]  = '{sw: 1, vld: 1, last: 0, d: fill(0),                       x: fill(0),                     xl: 0, err: 0, sat: 0};
        tbl[9]  = '{sw: 1, vld: 1, last: 0, d: lanes(-32768,-1,0,0,0,0,0,0),  x: fill(-32768),                xl: 0, err: 0, sat: 1};
        tbl[10] = '{sw: 1, vld: 1, last: 0, d: fill(0),                       x: fill(-32768),                xl: 0, err: 0, sat: 1};
        tbl[11] = '{sw: 0, vld: 1, last: 1, d: fill(0),                       x: fill(-32768),                xl: 1, err: 1, sat: 1};

        #12;
        chk("rst_valid", 128'(x_bus.valid), 128'(0));
        chk("rst_last",  128'(x_bus.last),  128'(0));
        chk("rst_data",  x_bus.data,        128'(0));
        chk("rst_sat",   128'(o_sat),       128'(0));
        chk("rst_err",   128'(o_frame_err), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            e = '{id: 0, vld: tbl[i].vld, x: tbl[i].x, xl: tbl[i].xl, err: tbl[i].err, sat: tbl[i].sat};
            tick(tbl[i].sw, tbl[i].vld, tbl[i].last, tbl[i].d, e);
        end

        run_frame(1'b1, 1024, 1'b1, -1, 1'b1, 0);
        run_frame(1'b0, 1024, 1'b0, -1, 1'b1, 0);
        run_frame(1'b1, 6, 1'b1, -1, 1'b0, 17);
        run_frame(1'b1, 6, 1'b1, 3, 1'b0, 17);
        run_frame(1'b0, 6, 1'b1, 2, 1'b0, 53);

        for (int b = 0; b < 4; b++) begin
            e = '{id: 0, vld: 1'b1, x: lanes(8*b+1, 8*b+2, 8*b+3, 8*b+4, 8*b+5, 8*b+6, 8*b+7, 8*b+8),
                  xl: 1'b0, err: 1'b0, sat: 1'b0};
            tick(1'b1, 1'b1, 1'b0, fill(1), e);
        end
        @(posedge clk);
        d_bus.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 128'(x_bus.valid), 128'(0));
        chk("midrst_last",  128'(x_bus.last),  128'(0));
        chk("midrst_data",  x_bus.data,        128'(0));
        chk("midrst_sat",   128'(o_sat),       128'(0));
        chk("midrst_err",   128'(o_frame_err), 128'(0));
        sbq.delete();
        hold_x = '0;
        hold_sat = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        e = '{id: 0, vld: 1'b1, x: lanes(1,2,3,4,5,6,7,8), xl: 1'b0, err: 1'b0, sat: 1'b0};
        tick(1'b1, 1'b1, 1'b0, fill(1), e);
        idle();
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
